adder_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 32-bit square-root carry-select adder (`SQRT_CSLA_ZFC`) among NREQ requesters, e.g. PC+4, branch target, load/store address generation and ALU add/sub. Each requester issues an add or subtract with a valid/ready handshake. One requester is granted per cycle. The result, carry-out, zero flag and requester ID are registered into a one-entry output buffer with backpressure.

---
 rtl/adder_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_adder_rr_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one 32-bit square-root carry-select adder among NREQ requesters.
// Optional signed-overflow output rsp_ovf is enabled by defining ADDER_ARB_OVF_EN.

module sqrt_csla_zfc (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout,
  output logic        zero
);
  localparam int NBLK = 7;
  localparam int BLO [NBLK] = '{0, 2, 4, 7, 11, 16, 22};
  localparam int BW  [NBLK] = '{2, 2, 3, 4, 5, 6, 10};

  logic [NBLK:0] c;
  assign c[0] = cin;

  // each block precomputes both carry-in cases; the incoming carry only drives a mux
  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    localparam int LO = BLO[k];
    localparam int W  = BW[k];
    logic [W:0] s0, s1;
    assign s0 = {1'b0, a[LO +: W]} + {1'b0, b[LO +: W]};
    assign s1 = {1'b0, a[LO +: W]} + {1'b0, b[LO +: W]} + {{W{1'b0}}, 1'b1};
    assign sum[LO +: W] = c[k] ? s1[W-1:0] : s0[W-1:0];
    assign c[k+1]       = c[k] ? s1[W]     : s0[W];
  end

  assign cout = c[NBLK];
  assign zero = ~|sum;
endmodule

module adder_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ-1:0]    req_sub,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [31:0]        rsp_sum,
  output logic               rsp_cout,
  output logic               rsp_zero
`ifdef ADDER_ARB_OVF_EN
  ,
  output logic               rsp_ovf
`endif
);
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt;
  logic [IDW-1:0] ptr_nxt;
  logic [IDW:0]   idx;
  logic           found;
  logic           can_accept;
  logic           xfer;
  logic [31:0]    a_sel, b_sel, b_eff;
  logic           sub_sel;
  logic [31:0]    add_sum;
  logic           add_cout, add_zero;

  // scan from the highest offset down so the nearest valid requester after ptr wins
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ))
        idx = idx - (IDW+1)'(NREQ);
      if (req_valid[idx[IDW-1:0]]) begin
        found = 1'b1;
        gnt   = idx[IDW-1:0];
      end
    end
  end

  assign can_accept = !rsp_valid || rsp_ready;
  assign xfer       = rst_n && found && can_accept;
  assign ptr_nxt    = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + IDW'(1);

  always_comb begin
    req_ready      = '0;
    req_ready[gnt] = xfer;
  end

  assign a_sel   = req_a[{gnt, 5'b0} +: 32];
  assign b_sel   = req_b[{gnt, 5'b0} +: 32];
  assign sub_sel = req_sub[gnt];
  assign b_eff   = sub_sel ? ~b_sel : b_sel;

  sqrt_csla_zfc u_add (
    .a    (a_sel),
    .b    (b_eff),
    .cin  (sub_sel),
    .sum  (add_sum),
    .cout (add_cout),
    .zero (add_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_zero  <= 1'b0;
      rsp_id    <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      rsp_valid <= 1'b1;
      rsp_sum   <= add_sum;
      rsp_cout  <= add_cout;
      rsp_zero  <= add_zero;
      rsp_id    <= gnt;
      ptr       <= ptr_nxt;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef ADDER_ARB_OVF_EN
  // with b already inverted for subtract, both cases reduce to the add rule on b_eff
  always_ff @(posedge clk) begin
    if (!rst_n)
      rsp_ovf <= 1'b0;
    else if (xfer)
      rsp_ovf <= ~(a_sel[31] ^ b_eff[31]) & (add_sum[31] ^ a_sel[31]);
  end
`endif

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Randomized and directed bench for adder_rr_arbiter against a transaction-level model.
// Define ADDER_ARB_OVF_EN to also check rsp_ovf.

module tb_adder_rr_arbiter;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid, req_ready, req_sub;
  logic [127:0] req_a, req_b;
  logic         rsp_valid, rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_sum;
  logic         rsp_cout, rsp_zero;
`ifdef ADDER_ARB_OVF_EN
  logic         rsp_ovf;
`endif

  logic [31:0]  ra [4];
  logic [31:0]  rb [4];

  always #5 clk = ~clk;

  for (genvar i = 0; i < 4; i++) begin : g_pack
    assign req_a[32*i +: 32] = ra[i];
    assign req_b[32*i +: 32] = rb[i];
  end

  adder_rr_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_zero  (rsp_zero)
`ifdef ADDER_ARB_OVF_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  int          total = 0;
  int          bad   = 0;
  int          m_ptr = 0;
  int          m_id  = 0;
  int          acc   = -1;
  bit          m_valid = 1'b0;
  logic [31:0] m_sum = '0;
  bit          m_cout = 1'b0, m_zero = 1'b0, m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_ptr + k) % 4;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic void calc(input logic [31:0] a, input logic [31:0] b, input logic s,
                               output logic [31:0] sum, output bit co, output bit z, output bit ov);
    logic [32:0] wide;
    if (s) begin
      sum = a - b;
      co  = (a >= b);
      ov  = (a[31] != b[31]) && (sum[31] != a[31]);
    end else begin
      wide = {1'b0, a} + {1'b0, b};
      sum  = wide[31:0];
      co   = wide[32];
      ov   = (a[31] == b[31]) && (sum[31] != a[31]);
    end
    z = (sum == 32'd0);
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // one clock: check ready before the edge, advance the model, check outputs after it
  task automatic cycle();
    int         g;
    bit         can;
    logic [3:0] er;
    #1;
    g  = pick();
    can = !m_valid || rsp_ready;
    er = 4'b0;
    if (rst_n && can && g >= 0) er[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    @(posedge clk);
    acc = -1;
    if (!rst_n) begin
      m_valid = 0; m_sum = '0; m_cout = 0; m_zero = 0; m_ovf = 0; m_id = 0; m_ptr = 0;
    end else if (er != 4'b0) begin
      calc(ra[g], rb[g], req_sub[g], m_sum, m_cout, m_zero, m_ovf);
      m_valid = 1;
      m_id    = g;
      m_ptr   = (g + 1) % 4;
      acc     = g;
    end else if (m_valid && rsp_ready) begin
      m_valid = 0;
    end
    #1;
    chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    chk("rsp_sum",   64'(rsp_sum),   64'(m_sum));
    chk("rsp_cout",  64'(rsp_cout),  64'(m_cout));
    chk("rsp_zero",  64'(rsp_zero),  64'(m_zero));
    chk("rsp_id",    64'(rsp_id),    64'(m_id));
`ifdef ADDER_ARB_OVF_EN
    chk("rsp_ovf",   64'(rsp_ovf),   64'(m_ovf));
`endif
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] held_sum;
    logic [1:0]  held_id;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    req_sub = 4'b0;
    for (int i = 0; i < 4; i++) begin ra[i] = rnd32(); rb[i] = rnd32(); end

    // reset held with everyone requesting
    repeat (3) cycle();
    rst_n = 1'b1;
    #1 chk("first_gnt", 64'(req_ready), 64'(4'b0001));
    cycle();
    req_valid = 4'b0;
    cycle();

    // single add with wrap to zero
    req_valid = 4'b0100; ra[2] = 32'hFFFF_FFFF; rb[2] = 32'h1; req_sub[2] = 1'b0;
    cycle();
    req_valid = 4'b0;
    chk("add_sum",  64'(rsp_sum),  64'(32'h0));
    chk("add_cout", 64'(rsp_cout), 64'(1'b1));
    chk("add_zero", 64'(rsp_zero), 64'(1'b1));
    chk("add_id",   64'(rsp_id),   64'(2'd2));
`ifdef ADDER_ARB_OVF_EN
    chk("add_ovf",  64'(rsp_ovf),  64'(1'b0));
`endif

    // subtract with borrow, then signed overflow
    req_valid = 4'b0010; ra[1] = 32'd5; rb[1] = 32'd7; req_sub[1] = 1'b1;
    cycle();
    chk("sub_sum",  64'(rsp_sum),  64'(32'hFFFF_FFFE));
    chk("sub_cout", 64'(rsp_cout), 64'(1'b0));
    chk("sub_zero", 64'(rsp_zero), 64'(1'b0));
    ra[1] = 32'h8000_0000; rb[1] = 32'h1;
    cycle();
    req_valid = 4'b0;
    chk("subo_sum",  64'(rsp_sum),  64'(32'h7FFF_FFFF));
    chk("subo_cout", 64'(rsp_cout), 64'(1'b1));
`ifdef ADDER_ARB_OVF_EN
    chk("subo_ovf",  64'(rsp_ovf),  64'(1'b1));
`endif

    // fairness from a fresh pointer
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("fair_id",    64'(rsp_id),    64'(i % 4));
      chk("fair_valid", 64'(rsp_valid), 64'(1'b1));
      if (acc >= 0) begin
        ra[acc] = rnd32(); rb[acc] = rnd32(); req_sub[acc] = 1'($urandom);
      end
    end

    // backpressure: buffer full from requester 2, then 0 and 3 wait
    req_valid = 4'b0; cycle(); cycle();
    req_valid = 4'b0100; rsp_ready = 1'b0;
    cycle();
    held_sum = rsp_sum; held_id = rsp_id;
    req_valid = 4'b1001;
    repeat (5) begin
      cycle();
      chk("bp_sum", 64'(rsp_sum), 64'(held_sum));
      chk("bp_id",  64'(rsp_id),  64'(held_id));
    end
    rsp_ready = 1'b1;
    cycle();
    chk("bp_refill_id",    64'(rsp_id),    64'(2'd3));
    chk("bp_refill_valid", 64'(rsp_valid), 64'(1'b1));

    // reset while a result is stalled
    req_valid = 4'b0010; rsp_ready = 1'b0;
    cycle();
    req_valid = 4'b1111;
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    chk("mr_valid", 64'(rsp_valid), 64'(1'b0));
    chk("mr_sum",   64'(rsp_sum),   64'(32'h0));
    rsp_ready = 1'b1;
    #1 chk("mr_gnt", 64'(req_ready), 64'(4'b0001));
    cycle();

    // randomized traffic; pending requesters keep their operands until accepted
    for (int n = 0; n < 3000; n++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      cycle();
      if (acc >= 0) req_valid[acc] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          ra[i] = rnd32(); rb[i] = rnd32(); req_sub[i] = 1'($urandom);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
